spi_master_m: RTL and testbench

Clocked SPI master for the 8-bit byte-oriented slave (spi_slave_m) used across the design. Takes a byte and a start strobe from the local controller and runs one full-duplex transfer: CS framing, divided SCK, MOSI shifted out and MISO captured. Uses the slave's timing: SCK idles low, data sampled on rising SCK, changed on falling SCK, LSB first, CS released between bytes.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_div.sv | 39 +++
 rtl/spi_master_m.sv | 168 ++++++++++++++++
 tb/tb_spi_master_m.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master: FSM state encoding, byte width
// and divider counter sizing.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD,
        GAP
    } spi_state_t;

    // Counter width able to hold CLK_DIV-1, with one spare bit so CLK_DIV=1 still gets a 1-bit counter.
    function automatic int div_cnt_w(input int div);
        return $clog2(div) + 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: pulses tick every CLK_DIV cycles while run is high,
// and restarts from zero whenever run drops.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = div_cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (!run || (cnt_reg == CNT_LAST)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    assign tick = run && (cnt_reg == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/spi_master_m.sv
// Byte-wide SPI master (SCK idle low, sample on rising SCK, shift on falling SCK,
// LSB first) with CS framing per byte and a CS-high gap before the next accept.
module spi_master_m
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = SPI_BYTE_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [DATA_W-1:0] TX_DATA,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              CS,
    output logic              SCK,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    spi_state_t state_reg, state_next;
    logic [DATA_W-1:0] tx_reg, tx_next;
    logic [DATA_W-1:0] rx_reg, rx_next;
    logic [DATA_W-1:0] rx_data_reg, rx_data_next;
    logic [BIT_W-1:0]  bit_reg, bit_next;
    logic [BIT_W-1:0]  bit_inc;
    logic              last_reg, last_next;
    logic              cs_reg, cs_next;
    logic              sck_reg, sck_next;
    logic              mosi_reg, mosi_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              tick;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .CLK   (CLK),
        .RST_N (RST_N),
        .run   (state_reg != IDLE),
        .tick  (tick)
    );

    assign bit_inc = bit_reg + BIT_W'(1);

    always_comb begin
        state_next   = state_reg;
        tx_next      = tx_reg;
        rx_next      = rx_reg;
        rx_data_next = rx_data_reg;
        bit_next     = bit_reg;
        last_next    = last_reg;
        cs_next      = cs_reg;
        sck_next     = sck_reg;
        mosi_next    = mosi_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (START) begin
                    tx_next    = TX_DATA;
                    rx_next    = '0;
                    bit_next   = '0;
                    last_next  = 1'b0;
                    cs_next    = 1'b0;
                    busy_next  = 1'b1;
                    mosi_next  = TX_DATA[0];
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sck_next         = 1'b1;
                    rx_next[bit_reg] = MISO;
                    state_next       = SCK_HI;
                end
            end
            SCK_HI: begin
                if (tick) begin
                    sck_next   = 1'b0;
                    state_next = SCK_LO;
                    if (bit_reg == BIT_LAST) begin
                        last_next = 1'b1;
                    end else begin
                        bit_next  = bit_inc;
                        mosi_next = tx_reg[bit_inc];
                    end
                end
            end
            SCK_LO: begin
                // After the 8th falling edge the low half-period runs out without a new rise.
                if (tick) begin
                    if (last_reg) begin
                        state_next = HOLD;
                    end else begin
                        sck_next         = 1'b1;
                        rx_next[bit_reg] = MISO;
                        state_next       = SCK_HI;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_next      = 1'b1;
                    rx_data_next = rx_reg;
                    done_next    = 1'b1;
                    state_next   = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_reg      <= '0;
            rx_reg      <= '0;
            rx_data_reg <= '0;
            bit_reg     <= '0;
            last_reg    <= 1'b0;
            cs_reg      <= 1'b1;
            sck_reg     <= 1'b0;
            mosi_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            tx_reg      <= tx_next;
            rx_reg      <= rx_next;
            rx_data_reg <= rx_data_next;
            bit_reg     <= bit_next;
            last_reg    <= last_next;
            cs_reg      <= cs_next;
            sck_reg     <= sck_next;
            mosi_reg    <= mosi_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign RX_DATA = rx_data_reg;
    assign BUSY    = busy_reg;
    assign DONE    = done_reg;
    assign CS      = cs_reg;
    assign SCK     = sck_reg;
    assign MOSI    = mosi_reg;

endmodule

// File: tb/tb_spi_master_m.sv
// Directed bench for spi_master_m: two builds (CLK_DIV=4 and CLK_DIV=1), each
// talking to a behavioural byte slave; expected values are hand-computed.
module tb_spi_master_m;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT with CLK_DIV=4
    logic       start4, cs4, sck4, mosi4, busy4, done4;
    logic [7:0] tx4, rx4;
    logic       s4_miso;
    // DUT with CLK_DIV=1
    logic       start1, cs1, sck1, mosi1, busy1, done1;
    logic [7:0] tx1, rx1;
    logic       s1_miso;

    spi_master_m #(.CLK_DIV(4), .DATA_W(8)) dut4 (
        .CLK(clk), .RST_N(rst_n), .START(start4), .TX_DATA(tx4), .RX_DATA(rx4),
        .BUSY(busy4), .DONE(done4), .CS(cs4), .SCK(sck4), .MOSI(mosi4), .MISO(s4_miso)
    );

    spi_master_m #(.CLK_DIV(1), .DATA_W(8)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .TX_DATA(tx1), .RX_DATA(rx1),
        .BUSY(busy1), .DONE(done1), .CS(cs1), .SCK(sck1), .MOSI(mosi1), .MISO(s1_miso)
    );

    // Behavioural slaves: index cleared on CS fall, sample on rising SCK, shift on falling SCK.
    logic [7:0] s4_dout, s4_din, s1_dout, s1_din;
    logic [2:0] s4_idx, s1_idx;
    int s4_rise = 0, s4_fall = 0, s4_r0 = 0, s4_r7 = 0, viol4 = 0;
    int s1_rise = 0, s1_fall = 0, s1_r0 = 0, s1_r7 = 0, viol1 = 0;

    always @(negedge cs4) begin
        s4_idx = 3'd0; s4_miso = s4_dout[0]; s4_rise = 0; s4_fall = 0;
    end
    always @(posedge sck4) begin
        if (cs4 === 1'b0) begin
            s4_din[s4_idx] = mosi4;
            if (s4_rise == 0) s4_r0 = cyc;
            s4_r7 = cyc;
            s4_rise++;
        end else begin
            viol4++;
        end
    end
    always @(negedge sck4) begin
        if (cs4 === 1'b0) begin
            s4_fall++;
            s4_idx = s4_idx + 3'd1;
            s4_miso = s4_dout[s4_idx];
        end else if (rst_n === 1'b1) begin
            viol4++;
        end
    end

    always @(negedge cs1) begin
        s1_idx = 3'd0; s1_miso = s1_dout[0]; s1_rise = 0; s1_fall = 0;
    end
    always @(posedge sck1) begin
        if (cs1 === 1'b0) begin
            s1_din[s1_idx] = mosi1;
            if (s1_rise == 0) s1_r0 = cyc;
            s1_r7 = cyc;
            s1_rise++;
        end else begin
            viol1++;
        end
    end
    always @(negedge sck1) begin
        if (cs1 === 1'b0) begin
            s1_fall++;
            s1_idx = s1_idx + 3'd1;
            s1_miso = s1_dout[s1_idx];
        end else if (rst_n === 1'b1) begin
            viol1++;
        end
    end

    // View of whichever DUT the current test drives
    bit         use1 = 1'b0;
    logic       v_cs, v_done, v_busy;
    logic [7:0] v_rx, v_din;
    int         v_rise, v_fall, v_span;
    assign v_cs   = use1 ? cs1 : cs4;
    assign v_done = use1 ? done1 : done4;
    assign v_busy = use1 ? busy1 : busy4;
    assign v_rx   = use1 ? rx1 : rx4;
    assign v_din  = use1 ? s1_din : s4_din;
    assign v_rise = use1 ? s1_rise : s4_rise;
    assign v_fall = use1 ? s1_fall : s4_fall;
    assign v_span = use1 ? (s1_r7 - s1_r0) : (s4_r7 - s4_r0);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic b);
        if (use1) start1 = b; else start4 = b;
    endtask

    task automatic drive_tx(input logic [7:0] d);
        if (use1) tx1 = d; else tx4 = d;
    endtask

    task automatic set_dout(input logic [7:0] d);
        if (use1) s1_dout = d; else s4_dout = d;
    endtask

    // Per-run observations; index 0/1 = first/second DONE pulse
    int         dones, cs_low, cs_gap;
    int         done_n [2];
    logic [7:0] rx_at  [2];
    logic [7:0] din_at [2];
    int         rise_at[2];
    int         fall_at[2];
    int         span_at[2];

    // Cycle n=1 is the cycle right after the accept edge.
    task automatic run_frames(input int ncyc, input logic [7:0] tx_a, input logic [7:0] tx_b,
                              input logic [7:0] dout_a, input logic [7:0] dout_b,
                              input bit hold, input bit inject);
        int n;
        dones = 0; cs_low = 0; cs_gap = 0;
        set_dout(dout_a);
        @(negedge clk);
        drive_tx(tx_a);
        drive_start(1'b1);
        @(posedge clk); #1;
        if (!hold) drive_start(1'b0);
        drive_tx(tx_b);
        n = 1;
        while (n <= ncyc) begin
            if (v_done === 1'b1) begin
                if (dones < 2) begin
                    done_n[dones]  = n;
                    rx_at[dones]   = v_rx;
                    din_at[dones]  = v_din;
                    rise_at[dones] = v_rise;
                    fall_at[dones] = v_fall;
                    span_at[dones] = v_span;
                end
                dones++;
                if (dones == 1) set_dout(dout_b);
            end
            if (v_cs === 1'b0) cs_low++;
            if (dones == 1 && v_cs === 1'b1) cs_gap++;
            if (inject) drive_start(n == 10 || n == 73 || n == 76);
            if (hold && dones >= 1 && v_cs === 1'b0) drive_start(1'b0);
            @(posedge clk); #1;
            n++;
        end
        drive_start(1'b0);
    endtask

    initial begin
        int k, nd;
        rst_n = 1'b0;
        start4 = 1'b0; start1 = 1'b0;
        tx4 = 8'h00; tx1 = 8'h00;
        s4_dout = 8'h00; s1_dout = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", {31'd0, cs4}, 32'd1);
        chk("rst_sck", {31'd0, sck4}, 32'd0);
        chk("rst_mosi", {31'd0, mosi4}, 32'd0);
        chk("rst_rx", {24'd0, rx4}, 32'h0);
        chk("rst_busy", {31'd0, busy4}, 32'd0);
        chk("rst_done", {31'd0, done4}, 32'd0);
        chk("rst_cs_div1", {31'd0, cs1}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: loopback A5/3C, timing of DONE and CS
        run_frames(100, 8'h3C, 8'hFF, 8'hA5, 8'hA5, 1'b0, 1'b0);
        chk("t1_dones", dones, 1);
        chk("t1_done_cycle", done_n[0], 73);
        chk("t1_cs_low", cs_low, 72);
        chk("t1_rx", {24'd0, rx_at[0]}, 32'hA5);
        chk("t1_slave_din", {24'd0, din_at[0]}, 32'h3C);
        chk("t1_rise_span", span_at[0], 56);
        chk("t1_busy_end", {31'd0, busy4}, 32'd0);

        // 2: bit order and edge counts
        run_frames(100, 8'h01, 8'h80, 8'h7E, 8'h7E, 1'b0, 1'b0);
        chk("t2_slave_din", {24'd0, din_at[0]}, 32'h01);
        chk("t2_rises", rise_at[0], 8);
        chk("t2_falls", fall_at[0], 8);
        chk("t2_rx", {24'd0, rx_at[0]}, 32'h7E);

        // 3: START during busy, DONE and GAP cycles is ignored
        run_frames(120, 8'h5A, 8'hFF, 8'h0F, 8'h0F, 1'b0, 1'b1);
        chk("t3_dones", dones, 1);
        chk("t3_cs_low", cs_low, 72);
        chk("t3_slave_din", {24'd0, din_at[0]}, 32'h5A);
        chk("t3_rx", {24'd0, rx_at[0]}, 32'h0F);
        chk("t3_busy_end", {31'd0, busy4}, 32'd0);

        // 4: back-to-back with START held high
        run_frames(180, 8'h11, 8'h22, 8'h55, 8'hAA, 1'b1, 1'b0);
        chk("t4_dones", dones, 2);
        chk("t4_rx0", {24'd0, rx_at[0]}, 32'h55);
        chk("t4_rx1", {24'd0, rx_at[1]}, 32'hAA);
        chk("t4_din0", {24'd0, din_at[0]}, 32'h11);
        chk("t4_din1", {24'd0, din_at[1]}, 32'h22);
        chk("t4_cs_gap_ge4", {31'd0, cs_gap >= 4}, 32'd1);
        chk("t4_spacing", done_n[1] - done_n[0], 77);

        // 5: reset after the 3rd rising SCK
        s4_dout = 8'hE7;
        @(negedge clk);
        tx4 = 8'h5A; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        k = 0;
        while (s4_rise < 3 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t5_reach_rise3", s4_rise, 3);
        rst_n = 1'b0;
        #1;
        chk("t5_cs", {31'd0, cs4}, 32'd1);
        chk("t5_sck", {31'd0, sck4}, 32'd0);
        chk("t5_busy", {31'd0, busy4}, 32'd0);
        chk("t5_rx", {24'd0, rx4}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 80; i++) begin
            if (done4 === 1'b1) nd++;
            @(posedge clk); #1;
        end
        chk("t5_no_done", nd, 0);
        run_frames(100, 8'hC3, 8'h00, 8'h81, 8'h81, 1'b0, 1'b0);
        chk("t5_dones", dones, 1);
        chk("t5_rx_after", {24'd0, rx_at[0]}, 32'h81);
        chk("t5_din_after", {24'd0, din_at[0]}, 32'hC3);

        // 6: CLK_DIV=1 build
        use1 = 1'b1;
        run_frames(40, 8'h96, 8'h00, 8'h69, 8'h69, 1'b0, 1'b0);
        chk("t6_dones", dones, 1);
        chk("t6_rx", {24'd0, rx_at[0]}, 32'h69);
        chk("t6_slave_din", {24'd0, din_at[0]}, 32'h96);
        chk("t6_cs_low", cs_low, 18);
        chk("t6_done_cycle", done_n[0], 19);
        chk("t6_rise_span", span_at[0], 14);
        chk("t6_rises", rise_at[0], 8);

        chk("sck_while_cs_high_div4", viol4, 0);
        chk("sck_while_cs_high_div1", viol1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
